// File: rtl/spi_dac_frame_receiver.sv
// SPI DAC frame receiver: shifts in MSB-first frames on CLK_71Khz and buffers the data field.
// Define SPI_RX_SAMPLE_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module spi_dac_frame_receiver #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK_71Khz,
    input  logic                 reset_n,
    input  logic                 input_SPI_SYNC_n,
    input  logic                 input_SPI_DIN,
    input  logic                 read_n,
    output logic [DATA_BITS-1:0] sample_out,
    output logic                 data_ready,
    output logic                 sample_valid,
    output logic                 power_down,
    output logic                 frame_error,
    output logic                 overrun,
    output logic [2:0]           fifo_count,
    output logic [1:0]           state_dbg
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-2:0] shift_reg;
    logic [FRAME_BITS-1:0] word_in;
    logic                  start, shift_en, commit, truncate;
    logic                  mode_zero, accept, do_read;
    logic                  unused_word;

    // word_in is the frame as it stands once the current DIN bit is appended
    assign word_in     = {shift_reg, input_SPI_DIN};
    assign mode_zero   = (word_in[DATA_BITS+1:DATA_BITS] == 2'b00);
    assign accept      = commit && mode_zero;
    assign do_read     = !read_n && data_ready;
    assign state_dbg   = state;
    assign unused_word = ^word_in[FRAME_BITS-1:DATA_BITS+2];

    always_ff @(posedge CLK_71Khz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        truncate  = 1'b0;
        case (state)
            IDLE: if (!input_SPI_SYNC_n) begin
                start     = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: if (input_SPI_SYNC_n) begin
                truncate  = 1'b1;
                state_nxt = IDLE;
            end else begin
                shift_en = 1'b1;
                if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    commit    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: if (input_SPI_SYNC_n) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_71Khz or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (start) begin
            bit_cnt   <= CNT_W'(1);
            shift_reg <= {{(FRAME_BITS-2){1'b0}}, input_SPI_DIN};
        end else if (shift_en) begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= word_in[FRAME_BITS-2:0];
        end else if (state_nxt == IDLE) begin
            bit_cnt   <= '0;
        end
    end

    always_ff @(posedge CLK_71Khz or negedge reset_n) begin
        if (!reset_n) begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            power_down   <= 1'b0;
        end else begin
            sample_valid <= accept;
            frame_error  <= truncate;
            if (commit) power_down <= !mode_zero;
        end
    end

`ifdef SPI_RX_SAMPLE_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [2:0]           count;
    logic                 full, push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count == 3'(FIFO_DEPTH));
    // a read on the same edge frees the slot the incoming sample needs
    assign push = accept && (!full || do_read);

    always_ff @(posedge CLK_71Khz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= accept && full && !do_read;
            if (push) begin
                mem[wr_ptr] <= word_in[DATA_BITS-1:0];
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_read) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign sample_out = mem[rd_ptr];
    assign data_ready = (count != 3'd0);
    assign fifo_count = count;
`else
    localparam int fifo_depth_unused = FIFO_DEPTH;

    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_full;

    always_ff @(posedge CLK_71Khz or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= accept && hold_full && !do_read;
            if (accept) begin
                hold_reg  <= word_in[DATA_BITS-1:0];
                hold_full <= 1'b1;
            end else if (do_read) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign sample_out = hold_reg;
    assign data_ready = hold_full;
    assign fifo_count = {2'b00, hold_full};
`endif
endmodule

// File: doc/spi_dac_frame_receiver.md
SPI_DAC_FRAME_RECEIVER -- requirements
Module: spi_dac_frame_receiver

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 16, meaning serial bits per frame that are captured.
REQ-002 SHALL have parameter DATA_BITS, default 12, meaning sample width taken from frame bits [11:0].
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning sample buffer entries (used only with SPI_RX_SAMPLE_FIFO_EN).
REQ-004 SHALL have port CLK_71Khz  input  1  SPI serial clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port input_SPI_SYNC_n  input  1  frame select, active low.
REQ-007 SHALL have port input_SPI_DIN  input  1  serial data, MSB first.
REQ-008 SHALL have port read_n  input  1  active-low consume strobe for the presented sample.
REQ-009 SHALL have port sample_out  output  DATA_BITS  oldest unread sample.
REQ-010 SHALL have port data_ready  output  1  high while at least one unread sample is held.
REQ-011 SHALL have port sample_valid  output  1  one-cycle pulse per accepted sample.
REQ-012 SHALL have port power_down  output  1  high when the last complete frame had mode bits [13:12] != 00.
REQ-013 SHALL have port frame_error  output  1  one-cycle pulse when a frame is truncated.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse when a sample is lost.
REQ-015 SHALL have port fifo_count  output  3  number of unread samples held.

Function
REQ-016 SHALL implement states IDLE, SHIFT, HOLD.
REQ-017 In IDLE, an edge with SYNC_n=0 SHALL capture DIN as frame bit 15, set bit count to 1, and move to SHIFT.
REQ-018 In SHIFT, an edge with SYNC_n=0 SHALL shift DIN in at the LSB and increment the bit count.
REQ-019 In SHIFT, the edge capturing bit FRAME_BITS-1 (count 15->16) SHALL commit word {shift[14:0],DIN} and move to HOLD.
REQ-020 In SHIFT, an edge with SYNC_n=1 SHALL discard the partial word, pulse frame_error next cycle, and return to IDLE.
REQ-021 In HOLD, DIN SHALL be ignored; an edge with SYNC_n=1 SHALL return to IDLE; trailing bits never cause frame_error.
REQ-022 On commit, word[13:12]==00 SHALL clear power_down and store word[11:0]; bits [15:14] are don't-care.
REQ-023 On commit, word[13:12]!=00 SHALL set power_down and discard the data with no sample_valid and no store.
REQ-024 sample_valid SHALL be high for exactly the cycle after the committing edge; latency from the 16th bit edge to visible sample_out and data_ready is 1 cycle.
REQ-025 read_n=0 while data_ready=1 SHALL consume the presented sample on that edge; read_n=0 while data_ready=0 SHALL be ignored.
REQ-026 A read_n level held low SHALL consume one sample per edge.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, bit count 0, and shift register 0.
REQ-028 reset_n=0 SHALL drive sample_out=0, data_ready=0, sample_valid=0, power_down=0, frame_error=0, overrun=0, and fifo_count=0.
REQ-029 Reset mid-frame SHALL discard the partial frame with no frame_error; the first frame after release SHALL begin at the first edge with SYNC_n=0.

Configuration
REQ-030 Macro SPI_RX_SAMPLE_FIFO_EN undefined: storage SHALL be a single holding register, and fifo_count SHALL read 0 or 1.
REQ-031 Without the macro, a commit while data_ready=1 and no read SHALL overwrite the held sample and pulse overrun.
REQ-032 Without the macro, a commit and a read on the same edge SHALL leave the new sample held with data_ready=1 and no overrun.
REQ-033 Macro SPI_RX_SAMPLE_FIFO_EN defined: storage SHALL be a FIFO_DEPTH circular FIFO with wrapping pointers; sample_out SHALL present the head entry.
REQ-034 With the macro, a commit while full SHALL drop the new sample and pulse overrun; a commit and a read on the same edge while full SHALL do both, with no overrun and the count unchanged.
REQ-035 With the macro, a commit and a read on the same edge with count==1 SHALL present the new sample next cycle.

Verification
REQ-036 Frame 0x0ABC (SYNC_n low for 22 edges) -> sample_out=0xABC, sample_valid 1 cycle after the 16th edge, data_ready=1, fifo_count=1.
REQ-037 Frame 0x1123 -> power_down=1, data_ready stays 0, no sample_valid; a following frame 0xC555 -> power_down=0 and sample_out=0x555.
REQ-038 SYNC_n rises after 9 bits -> frame_error pulse, no sample stored, and the next full frame 0x0001 is received as 0x001.
REQ-039 Without the macro, frames 0x0111 then 0x0222 with no read -> overrun pulse and sample_out=0x222; with the macro, 5 frames with no read -> fifo_count=4, overrun on the 5th, and reads return 0x111, 0x222, 0x333, 0x444.
REQ-040 reset_n asserted after 7 bits of frame 0x0FFF -> all outputs 0 immediately, no frame_error; the next frame 0x0800 -> sample_out=0x800.
REQ-041 With the macro, FIFO full plus a commit and read_n=0 on the same edge -> fifo_count stays 4, no overrun, and the head advances.
